// File: rtl/vc_buffer_arb.sv
// Two-VC circular buffer stage with registered single-port output arbitration.
// Optional macro RR_ARB_EN selects round-robin arbitration instead of fixed VC0 priority.
module vc_buffer_arb #(
  parameter int unsigned BITNUMBER      = 6,
  parameter int unsigned LENGTH         = 4,
  parameter int unsigned ALMOST_FULL_TH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] VC0_Data_in,
  input  logic                 VC0_wr,
  input  logic [BITNUMBER-1:0] VC1_Data_in,
  input  logic                 VC1_wr,
  input  logic                 out_stall,
  output logic [BITNUMBER-1:0] Data_out,
  output logic                 valid_out,
  output logic                 vc_out,
  output logic                 VC0_full,
  output logic                 VC0_empty,
  output logic                 VC1_full,
  output logic                 VC1_empty,
  output logic                 pause,
  output logic                 wr_error
);

  localparam int unsigned NUM_VC = 2;
  localparam int unsigned PTR_W  = $clog2(LENGTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [BITNUMBER-1:0] mem     [NUM_VC][LENGTH];
  logic [PTR_W-1:0]     wr_ptr  [NUM_VC];
  logic [PTR_W-1:0]     rd_ptr  [NUM_VC];
  logic [CNT_W-1:0]     cnt     [NUM_VC];

  logic [BITNUMBER-1:0] wr_data_c [NUM_VC];
  logic [NUM_VC-1:0]    wr_req_c;
  logic [NUM_VC-1:0]    full_c;
  logic [NUM_VC-1:0]    empty_c;
  logic [NUM_VC-1:0]    wr_ok_c;
  logic [NUM_VC-1:0]    pop_c;
  logic                 pop_en_c;
  logic                 win_c;

`ifdef RR_ARB_EN
  logic                 last_served;
`endif

  // Occupancy decode, write acceptance and arbitration from start-of-cycle counts
  always_comb begin
    wr_req_c     = {VC1_wr, VC0_wr};
    wr_data_c[0] = VC0_Data_in;
    wr_data_c[1] = VC1_Data_in;
    full_c       = '0;
    empty_c      = '0;
    pop_c        = '0;
    for (int v = 0; v < int'(NUM_VC); v++) begin
      full_c[v]  = (cnt[v] == CNT_W'(LENGTH));
      empty_c[v] = (cnt[v] == '0);
    end
    wr_ok_c  = wr_req_c & ~full_c;
    pop_en_c = !out_stall && !(&empty_c);
`ifdef RR_ARB_EN
    // With both VCs ready the one not served last wins; otherwise the ready one
    win_c = (empty_c == '0) ? ~last_served : empty_c[0];
`else
    win_c = empty_c[0];
`endif
    if (pop_en_c) begin
      pop_c[win_c] = 1'b1;
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < int'(NUM_VC); v++) begin
        if (wr_ok_c[v]) begin
          mem[v][wr_ptr[v]] <= wr_data_c[v];
        end
      end
    end
  end

  // Pointers, counts and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < int'(NUM_VC); v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
      Data_out  <= '0;
      valid_out <= 1'b0;
      vc_out    <= 1'b0;
      wr_error  <= 1'b0;
    end else begin
      for (int v = 0; v < int'(NUM_VC); v++) begin
        if (wr_ok_c[v]) begin
          wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        end
        if (pop_c[v]) begin
          rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        end
        cnt[v] <= cnt[v] + CNT_W'(wr_ok_c[v]) - CNT_W'(pop_c[v]);
      end
      valid_out <= pop_en_c;
      if (pop_en_c) begin
        Data_out <= mem[win_c][rd_ptr[win_c]];
        vc_out   <= win_c;
      end
      if (|(wr_req_c & full_c)) begin
        wr_error <= 1'b1;
      end
    end
  end

`ifdef RR_ARB_EN
  // Reset to VC1 so that VC0 is favoured on the first contended pop
  always_ff @(posedge clk) begin
    if (reset) begin
      last_served <= 1'b1;
    end else if (pop_en_c) begin
      last_served <= win_c;
    end
  end
`endif

  assign VC0_full  = full_c[0];
  assign VC0_empty = empty_c[0];
  assign VC1_full  = full_c[1];
  assign VC1_empty = empty_c[1];
  assign pause     = (cnt[0] >= CNT_W'(ALMOST_FULL_TH)) || (cnt[1] >= CNT_W'(ALMOST_FULL_TH));

endmodule

// File: tb/tb_vc_buffer_arb.sv
// Bench for vc_buffer_arb: directed scenarios plus random traffic against a queue-based model.
module tb_vc_buffer_arb;

  localparam int unsigned BW  = 6;
  localparam int unsigned LEN = 4;
  localparam int unsigned TH  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] VC0_Data_in = '0;
  logic          VC0_wr = 1'b0;
  logic [BW-1:0] VC1_Data_in = '0;
  logic          VC1_wr = 1'b0;
  logic          out_stall = 1'b0;
  logic [BW-1:0] Data_out;
  logic          valid_out;
  logic          vc_out;
  logic          VC0_full, VC0_empty, VC1_full, VC1_empty;
  logic          pause;
  logic          wr_error;

  vc_buffer_arb #(.BITNUMBER(BW), .LENGTH(LEN), .ALMOST_FULL_TH(TH)) dut (
    .clk(clk), .reset(reset),
    .VC0_Data_in(VC0_Data_in), .VC0_wr(VC0_wr),
    .VC1_Data_in(VC1_Data_in), .VC1_wr(VC1_wr),
    .out_stall(out_stall),
    .Data_out(Data_out), .valid_out(valid_out), .vc_out(vc_out),
    .VC0_full(VC0_full), .VC0_empty(VC0_empty),
    .VC1_full(VC1_full), .VC1_empty(VC1_empty),
    .pause(pause), .wr_error(wr_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one FIFO queue per VC plus expected output registers
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic [BW-1:0] m_data  = '0;
  bit            m_valid = 0;
  bit            m_vc    = 0;
  bit            m_err   = 0;
  bit            m_last  = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit w0, input logic [BW-1:0] d0,
                       input bit w1, input logic [BW-1:0] d1, input bit st);
    int  s0, s1;
    bit  win;
    if (rst) begin
      q0.delete(); q1.delete();
      m_data = '0; m_valid = 0; m_vc = 0; m_err = 0; m_last = 1;
      return;
    end
    s0 = q0.size();
    s1 = q1.size();
    if (!st && (s0 > 0 || s1 > 0)) begin
`ifdef RR_ARB_EN
      if (s0 > 0 && s1 > 0) win = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else                  win = (s0 == 0);
`else
      win = (s0 == 0);
`endif
      m_data  = win ? q1.pop_front() : q0.pop_front();
      m_vc    = win;
      m_valid = 1;
      m_last  = win;
    end else begin
      m_valid = 0;
    end
    if (w0) begin
      if (s0 == int'(LEN)) m_err = 1; else q0.push_back(d0);
    end
    if (w1) begin
      if (s1 == int'(LEN)) m_err = 1; else q1.push_back(d1);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge
  task automatic step(input bit rst, input bit w0, input logic [BW-1:0] d0,
                      input bit w1, input logic [BW-1:0] d1, input bit st);
    reset = rst; VC0_wr = w0; VC0_Data_in = d0; VC1_wr = w1; VC1_Data_in = d1; out_stall = st;
    model(rst, w0, d0, w1, d1, st);
    @(posedge clk);
    #1;
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("Data_out",  32'(Data_out),  32'(m_data));
    check("vc_out",    32'(vc_out),    32'(m_vc));
    check("VC0_empty", 32'(VC0_empty), 32'(q0.size() == 0));
    check("VC1_empty", 32'(VC1_empty), 32'(q1.size() == 0));
    check("VC0_full",  32'(VC0_full),  32'(q0.size() == int'(LEN)));
    check("VC1_full",  32'(VC1_full),  32'(q1.size() == int'(LEN)));
    check("pause",     32'(pause),     32'(q0.size() >= int'(TH) || q1.size() >= int'(TH)));
    check("wr_error",  32'(wr_error),  32'(m_err));
  endtask

  task automatic idle(input bit st);
    step(0, 0, '0, 0, '0, st);
  endtask

  logic [BW-1:0] exp_order [4];
  logic [BW-1:0] got;

  initial begin
    // Reset then idle
    step(1, 0, '0, 0, '0, 0);
    step(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 5; i++) idle(0);
    check("idle_valid", 32'(valid_out), 32'd0);
    check("idle_data",  32'(Data_out),  32'd0);

    // Single word latency
    step(0, 1, 6'h05, 0, '0, 0);
    check("lat_n1_valid", 32'(valid_out), 32'd0);
    idle(0);
    check("lat_valid", 32'(valid_out), 32'd1);
    check("lat_data",  32'(Data_out),  32'h05);
    check("lat_vc",    32'(vc_out),    32'd0);
    check("lat_empty", 32'(VC0_empty), 32'd1);

    // Fill VC1 under stall, overflow, then drain with pointer wrap
    step(0, 0, '0, 1, 6'h11, 1);
    step(0, 0, '0, 1, 6'h12, 1);
    check("pause_lo", 32'(pause), 32'd0);
    step(0, 0, '0, 1, 6'h13, 1);
    check("pause_hi", 32'(pause), 32'd1);
    step(0, 0, '0, 1, 6'h14, 1);
    check("vc1_full", 32'(VC1_full), 32'd1);
    step(0, 0, '0, 1, 6'h15, 1);
    check("ovf_err", 32'(wr_error), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      check("drain1_data", 32'(Data_out), 32'(6'h11 + i));
      check("drain1_vc",   32'(vc_out),   32'd1);
    end
    idle(0);
    check("drain1_done", 32'(valid_out), 32'd0);

    // Arbitration order with both VCs loaded
    step(0, 1, 6'h01, 1, 6'h21, 1);
    step(0, 1, 6'h02, 1, 6'h22, 1);
`ifdef RR_ARB_EN
    exp_order[0] = 6'h01; exp_order[1] = 6'h21; exp_order[2] = 6'h02; exp_order[3] = 6'h22;
`else
    exp_order[0] = 6'h01; exp_order[1] = 6'h02; exp_order[2] = 6'h21; exp_order[3] = 6'h22;
`endif
    for (int i = 0; i < 4; i++) begin
      idle(0);
      got = Data_out;
      check("arb_order", 32'(got), 32'(exp_order[i]));
    end
    idle(0);

    // Write to full VC0 while it pops: word dropped, count drops to 3
    step(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 6'(6'h30 + i), 0, '0, 1);
    check("vc0_full", 32'(VC0_full), 32'd1);
    step(0, 1, 6'h3F, 0, '0, 0);
    check("fullpop_err",   32'(wr_error), 32'd1);
    check("fullpop_full",  32'(VC0_full), 32'd0);
    check("fullpop_pause", 32'(pause),    32'd1);
    check("fullpop_data",  32'(Data_out), 32'h30);
    for (int i = 0; i < 4; i++) idle(0);
    check("fullpop_empty", 32'(VC0_empty), 32'd1);

    // Reset mid-transfer with a write in the reset cycle
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 6'(6'h08 + i), 1);
    idle(0);
    check("mid_valid", 32'(valid_out), 32'd1);
    step(1, 0, '0, 1, 6'h2A, 0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data",  32'(Data_out),  32'd0);
    check("rst_err",   32'(wr_error),  32'd0);
    check("rst_empty", 32'(VC1_empty), 32'd1);
    idle(0);
    idle(0);
    check("rst_nowrite", 32'(valid_out), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 45), BW'($urandom),
           ($urandom_range(0, 99) < 45), BW'($urandom),
           ($urandom_range(0, 99) < 35));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_buffer_arb.md
Name: vc_buffer_arb

Overview:
- Stage directly downstream of demux_id.
- Accepts the two virtual-channel streams (demux_to_VC0/demux_to_VC1 with their write strobes) into two independent circular buffers.
- Arbitrates between the buffers onto a single registered output toward the egress side.
- Raises pause back toward the main FIFO when either VC approaches full.

Parameters:
BITNUMBER, 6, data word width.
LENGTH, 4, depth of each VC buffer in words; must be a power of two and at least 2.
ALMOST_FULL_TH, 3, VC occupancy at or above which pause is asserted; valid range 1 to LENGTH.

Ports:
clk  input  1  single clock, all state updates on rising edge.
reset  input  1  synchronous, active-high; sampled on rising edge of clk.
VC0_Data_in  input  BITNUMBER  word from demux_to_VC0.
VC0_wr  input  1  write strobe for VC0 (from Fifo_wr0).
VC1_Data_in  input  BITNUMBER  word from demux_to_VC1.
VC1_wr  input  1  write strobe for VC1 (from Fifo_wr1).
out_stall  input  1  downstream back-pressure; 1 = do not pop this cycle.
Data_out  output  BITNUMBER  registered output word.
valid_out  output  1  Data_out carries a new word this cycle.
vc_out  output  1  VC of the word on Data_out (0 or 1).
VC0_full, VC0_empty, VC1_full, VC1_empty  output  1 each  occupancy flags.
pause  output  1  upstream back-pressure.
wr_error  output  1  sticky; set on a write to a full VC.

Behaviour:
- Each VC has:
  - LENGTH x BITNUMBER storage.
  - wr_ptr and rd_ptr, each log2(LENGTH) bits, wrapping naturally from LENGTH-1 to 0.
  - Occupancy count, log2(LENGTH)+1 bits, range 0..LENGTH.
- Flags are combinational from the registered counts:
  - full = (count == LENGTH)
  - empty = (count == 0)
  - pause = (VC0 count >= ALMOST_FULL_TH) or (VC1 count >= ALMOST_FULL_TH)
- Write rules:
  - VCn_wr=1 with VCn not full: store the word at wr_ptr, increment wr_ptr.
  - VCn_wr=1 with VCn full: drop the word and set wr_error. Full is judged on the count at the start of the cycle, so the write is dropped even if the same VC pops in that cycle.
- Pop eligibility: a pop is issued in a cycle only if out_stall=0 and at least one VC count > 0. The counts used are those at the start of the cycle.
  - A word written in cycle N is first poppable in cycle N+1.
  - Minimum write-to-valid_out latency is 2 cycles.
- Arbitration (default, fixed priority):
  - VC0 wins whenever non-empty.
  - VC1 is served only when VC0 is empty.
- On pop:
  - Data_out <= mem[rd_ptr] of the winning VC.
  - vc_out <= winner.
  - valid_out <= 1.
  - The winner's rd_ptr increments.
- No pop in a cycle: valid_out <= 0; Data_out and vc_out hold their previous values.
- Simultaneous write and pop on the same VC: both take effect and the count is unchanged. Otherwise the count changes by +1 (write only) or -1 (pop only).
- Writes on both VCs in the same cycle are fully independent.
- out_stall only blocks pops; writes continue while it is asserted.
- wr_error stays at 1 until reset.
- Reset, synchronous and taking priority over all other activity including mid-transfer:
  - All pointers and counts = 0; buffer contents are don't-care.
  - Data_out = 0, valid_out = 0, vc_out = 0, wr_error = 0.
  - Resulting outputs: VC0_empty = VC1_empty = 1, full flags = 0, pause = 0.
  - Any write or pop requested in the reset cycle is ignored.
  - The round-robin last-served register (see Optional Feature) = 1, so VC0 wins first.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-served register is updated on every pop.
  - When both VCs are non-empty, the VC not served last wins.
  - When only one VC is non-empty, it wins regardless of the register.
- Undefined: fixed VC0 priority as described above; no last-served register is instantiated.

Test Plan:
- Reset then idle 5 cycles -> valid_out=0, Data_out=0, both empty=1, pause=0, wr_error=0.
- Write 0x05 to VC0 in cycle N, out_stall=0 -> valid_out=1, Data_out=0x05, vc_out=0 at cycle N+2; VC0_empty=1 again afterwards.
- out_stall=1; write 0x11,0x12,0x13 to VC1 -> pause=1 once count reaches 3. Then write 0x14 -> VC1_full=1. Then write 0x15 -> dropped, wr_error=1. Release stall -> outputs 0x11,0x12,0x13,0x14 on consecutive cycles, vc_out=1, ptr wrap verified.
- With out_stall=1, preload VC0={0x01,0x02} and VC1={0x21,0x22}, then release stall:
  - Without RR_ARB_EN -> output order 0x01,0x02,0x21,0x22.
  - With RR_ARB_EN -> 0x01,0x21,0x02,0x22.
- VC0 holds 4 words (full). In the same cycle, write 0x3F to VC0 while it pops -> 0x3F dropped, wr_error=1, count becomes 3.
- Assert reset while VC1 holds 2 words and valid_out=1 -> next cycle: all counts 0, valid_out=0, Data_out=0, wr_error=0. A VC1 write issued during reset does not appear.
